ifetch_stage: RTL
=================

Name: ifetch_stage

Overview:
- Instruction-fetch stage of the single-issue RV64 core; sits directly upstream of the decode stage's opcode control decoder.
- Holds the PC and issues one instruction-bus request at a time.
- Buffers the returned 32-bit instruction in a one-entry output register and hands it to decode through a valid/ready handshake.
- Accepts redirects (branch/jal/jalr/exception) from later stages and discards any in-flight fetch on the wrong path.

Parameters:
- PC_RESET, 64'h0000_0000_8000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word emitted with a misaligned-PC exception (addi x0,x0,0).

Ports:
- clk  input  1  core clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- ireq_valid  output  1  instruction-bus request valid
- ireq_addr  output  64  request address; stable while ireq_valid=1 and no iresp_data_ok
- iresp_data_ok  input  1  one-cycle pulse: response data valid for the outstanding request
- iresp_data  input  32  instruction word, valid with iresp_data_ok
- redirect_valid  input  1  one-cycle pulse: fetch must restart at redirect_pc
- redirect_pc  input  64  redirect target
- if_valid  output  1  output register holds an instruction for decode
- if_pc  output  64  PC of the held instruction
- if_instr  output  32  held instruction; [6:0] feeds the decoder opcode
- if_excep  output  1  held entry is an instruction-address-misaligned fault
- id_ready  input  1  decode consumes the held entry this cycle

Behaviour:
- Reset (reset=1 at an edge):
  - pc<=PC_RESET, state<=S_FETCH.
  - if_valid=0, if_pc=0, if_instr=0, if_excep=0.
  - ireq_valid is forced to 0 combinationally while reset=1.
  - The bus shares this reset; no response may survive a reset.
- ireq_valid=1 only in S_FETCH with pc[1:0]==0, and in S_FLUSH. ireq_addr is always pc.
- S_FETCH:
  - Misaligned PC (pc[1:0]!=0): no request. Load the output register with if_pc=pc, if_instr=NOP_INSTR, if_excep=1, if_valid=1, then go to S_HOLD.
  - iresp_data_ok=1 and redirect_valid=0: load the output register with if_pc=pc, if_instr=iresp_data, if_excep=0, if_valid=1. Set pc<=pc+4 (64-bit wrap) and go to S_HOLD.
  - iresp_data_ok=1 and redirect_valid=1 in the same cycle: drop the data, pc<=redirect_pc, stay in S_FETCH.
  - redirect_valid=1 without iresp_data_ok: tgt<=redirect_pc, go to S_FLUSH. The request stays asserted with its old address because the bus cannot cancel.
- S_FLUSH:
  - Keep requesting the old pc.
  - A later redirect_valid overwrites tgt.
  - On iresp_data_ok: discard the data, pc<=(redirect_valid ? redirect_pc : tgt), go to S_FETCH.
  - if_valid stays 0 throughout.
- S_HOLD:
  - if_* outputs are stable and no request is issued.
  - redirect_valid has priority: if_valid<=0, pc<=redirect_pc, go to S_FETCH (id_ready is ignored that cycle).
  - Else if id_ready=1: if_valid<=0, go to S_FETCH.
  - Else stay in S_HOLD.
- Latency: a request is issued the cycle after entering S_FETCH. if_valid rises the cycle after iresp_data_ok. Zero-wait-state bus gives a best-case throughput of one instruction per 2 cycles.
- if_valid never asserts with wrong-path data: every response received in S_FLUSH, or coinciding with a redirect, is dropped.
- if_pc/if_instr/if_excep keep their values when if_valid=0 (no clearing).

Optional Feature:
- Macro IFETCH_PERF_EN.
- When defined, add two outputs:
  - perf_bus_wait (64 bits): counts cycles with ireq_valid=1 and iresp_data_ok=0.
  - perf_flush (32 bits): counts responses discarded in S_FLUSH or on a same-cycle redirect.
  - Both counters clear on reset and wrap silently.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then a bus with data_ok 1 cycle after request returning 0x00000033, id_ready=1 -> ireq_addr=0x80000000; if_valid=1, if_pc=0x80000000, if_instr=0x00000033; next request address 0x80000004.
- id_ready=0 for 5 cycles while if_valid=1 -> if_* unchanged, ireq_valid=0 for all 5; fetch of pc+4 begins the cycle after id_ready=1.
- Request at 0x80000008 with data_ok delayed 3 cycles; redirect_valid to 0x80000100 in wait cycle 1 -> ireq_addr stays 0x80000008 until data_ok; that data is dropped; next request 0x80000100; if_valid never shows 0x80000008.
- redirect_valid to 0x80000200 in the same cycle as iresp_data_ok -> data dropped, next ireq_addr=0x80000200, if_valid remains 0.
- Redirect to 0x80000102 -> no bus request; if_valid=1, if_excep=1, if_instr=0x00000013, if_pc=0x80000102.
- Redirect to 0x80000300 in S_HOLD while id_ready=1 -> held entry dropped, next ireq_addr=0x80000300; with IFETCH_PERF_EN defined, perf_flush increments only in the S_FLUSH and same-cycle redirect cases above.

Source files
------------

// File: rtl/ifetch_stage.sv
// ifetch_stage: RV64 instruction-fetch stage, one outstanding bus request, one-entry output register.
// Define IFETCH_PERF_EN to add the perf_bus_wait / perf_flush counters.
module ifetch_stage #(
    parameter logic [63:0] PC_RESET  = 64'h0000_0000_8000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        if_valid,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_excep,
    input  logic        id_ready
`ifdef IFETCH_PERF_EN
    ,
    output logic [63:0] perf_bus_wait,
    output logic [31:0] perf_flush
`endif
);
    typedef enum logic [1:0] {S_FETCH, S_FLUSH, S_HOLD} fetchState_e;

    fetchState_e state;
    logic [63:0] pc;
    logic [63:0] tgt;
    logic        pcAligned;

    assign pcAligned = (pc[1:0] == 2'b00);
    // NOTE: gated by reset combinationally so the bus never sees a request while reset is held.
    assign ireq_valid = !reset && (((state == S_FETCH) && pcAligned) || (state == S_FLUSH));
    assign ireq_addr  = pc;

    // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            pc       <= PC_RESET;
            tgt      <= '0;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= '0;
            if_excep <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (!pcAligned) begin
                        if_valid <= 1'b1;
                        if_pc    <= pc;
                        if_instr <= NOP_INSTR;
                        if_excep <= 1'b1;
                        state    <= S_HOLD;
                    end else if (iresp_data_ok && !redirect_valid) begin
                        if_valid <= 1'b1;
                        if_pc    <= pc;
                        if_instr <= iresp_data;
                        if_excep <= 1'b0;
                        pc       <= pc + 64'd4;
                        state    <= S_HOLD;
                    end else if (iresp_data_ok) begin
                        pc <= redirect_pc;
                    end else if (redirect_valid) begin
                        // The bus cannot cancel: keep requesting the old pc until it answers.
                        tgt   <= redirect_pc;
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (redirect_valid) tgt <= redirect_pc;
                    if (iresp_data_ok) begin
                        pc    <= redirect_valid ? redirect_pc : tgt;
                        state <= S_FETCH;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        if_valid <= 1'b0;
                        pc       <= redirect_pc;
                        state    <= S_FETCH;
                    end else if (id_ready) begin
                        if_valid <= 1'b0;
                        state    <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

`ifdef IFETCH_PERF_EN
    logic dropResp;
    assign dropResp = iresp_data_ok &&
                      ((state == S_FLUSH) || ((state == S_FETCH) && pcAligned && redirect_valid));

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_bus_wait <= '0;
            perf_flush    <= '0;
        end else begin
            if (ireq_valid && !iresp_data_ok) perf_bus_wait <= perf_bus_wait + 64'd1;
            if (dropResp) perf_flush <= perf_flush + 32'd1;
        end
    end
`endif

endmodule
